// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit arbiter and its helpers.
package uart_pkg;

    localparam logic [7:0] TAG_BASE = 8'hA0;
    localparam int         STALL_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        DATA = 2'd2
    } uart_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping.
// Returns the winner one-hot and as an index, plus whether anything won.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [IDXW-1:0] cand;

    // Scanning ptr+1 .. ptr+N visits ptr itself last, so the previous owner has lowest priority.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDXW'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding one uart_tx byte stream, with an
// optional source-tag byte per packet and a mid-packet stall watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int TAG_ENABLE   = 1,
    parameter int STALL_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PORTS-1:0]      s_valid,
    input  logic [NUM_PORTS-1:0][7:0] s_data,
    input  logic [NUM_PORTS-1:0]      s_last,
    output logic [NUM_PORTS-1:0]      s_ready,
    output logic                      m_valid,
    output logic [7:0]                m_data,
    input  logic                      m_ready,
    output logic [NUM_PORTS-1:0]      grant,
    output logic                      abort,
    output uart_arb_state_e           dbg_state
);

    localparam int                 IDXW      = $clog2(NUM_PORTS);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_CYCLES);
    localparam bit                 WD_EN     = (STALL_CYCLES != 0);

    // Handshake rule: a byte moves on a cycle where valid and ready are both high;
    // the sender holds valid and data stable until then.

    uart_arb_state_e      state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 abort_q, abort_d;

    logic [NUM_PORTS-1:0] rr_gnt;
    logic [IDXW-1:0]      rr_idx;
    logic                 rr_any;
    logic                 g_valid;
    logic                 g_last;

    rr_arbiter #(
        .N    (NUM_PORTS),
        .IDXW (IDXW)
    ) u_rr (
        .req (s_valid),
        .ptr (ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // The pointer always holds the current owner, so it doubles as the mux select.
    assign g_valid = s_valid[ptr_q];
    assign g_last  = s_last[ptr_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        abort_d = 1'b0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        s_ready = '0;

        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    grant_d = rr_gnt;
                    ptr_d   = rr_idx;
                    stall_d = '0;
                    state_d = (TAG_ENABLE != 0) ? TAG : DATA;
                end
            end

            TAG: begin
                m_valid = 1'b1;
                m_data  = TAG_BASE | {{(8-IDXW){1'b0}}, ptr_q};
                stall_d = '0;
                if (m_ready) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                m_valid        = g_valid;
                m_data         = s_data[ptr_q];
                s_ready[ptr_q] = m_ready;
                if (g_valid && m_ready) begin
                    stall_d = '0;
                    if (g_last) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else if (!g_valid) begin
                    if (stall_q != {STALL_W{1'b1}}) begin
                        stall_d = stall_q + 1'b1;
                    end
                    // Compare the next count so abort lands exactly STALL_CYCLES edges after the last byte.
                    if (WD_EN && (stall_d == STALL_LIM)) begin
                        abort_d = 1'b1;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IDXW'(NUM_PORTS - 1);
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end

    assign grant     = grant_q;
    assign abort     = abort_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-port byte sources, an expected byte
// stream on the uart side, and spot checks of grant/abort/state.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NP = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NP-1:0]       s_valid;
    logic [NP-1:0][7:0]  s_data;
    logic [NP-1:0]       s_last;
    logic [NP-1:0]       s_ready;
    logic                m_valid;
    logic [7:0]          m_data;
    logic                m_ready;
    logic [NP-1:0]       grant;
    logic                abort;
    uart_arb_state_e     dbg_state;

    uart_tx_arbiter #(
        .NUM_PORTS    (NP),
        .TAG_ENABLE   (1),
        .STALL_CYCLES (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .grant     (grant),
        .abort     (abort),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [8:0] src_q [NP][$];
    logic [7:0] exp_q [$];
    logic [NP-1:0] acc;
    logic       prev_hold;
    logic [7:0] prev_data;
    bit         rnd_ready;
    int         total;
    int         bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic [7:0] d, input bit last);
        src_q[p].push_back({last, d});
    endtask

    task automatic advance();
        logic [8:0] e;
        for (int p = 0; p < NP; p++) begin
            if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            if (src_q[p].size() > 0) begin
                e          = src_q[p][0];
                s_valid[p] = 1'b1;
                s_data[p]  = e[7:0];
                s_last[p]  = e[8];
            end else begin
                s_valid[p] = 1'b0;
                s_data[p]  = 8'h00;
                s_last[p]  = 1'b0;
            end
        end
        if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic monitor();
        acc = s_valid & s_ready;
        if (prev_hold) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("stray_byte", exp_q.size(), 1);
            else chk("stream", m_data, exp_q.pop_front());
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        advance();
        @(negedge clk);
        monitor();
    endtask

    task automatic clear_bench();
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        acc       = '0;
        prev_hold = 1'b0;
        s_valid   = '0;
        s_data    = '0;
        s_last    = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_bench();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && dbg_state == IDLE && s_valid == '0) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        chk("drain_done", done, 1);
    endtask

    initial begin
        int edges;
        total     = 0;
        bad       = 0;
        rnd_ready = 1'b0;
        m_ready   = 1'b1;
        reset     = 1'b0;
        clear_bench();

        // Reset state
        #3;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_grant", grant, 0);
        chk("rst_abort", abort, 0);
        chk("rst_state", dbg_state, IDLE);
        do_reset();

        // Port 1 sends 11, 22(last)
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b1);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        cycle();
        chk("a_idle_grant", grant, 0);
        chk("a_idle_valid", m_valid, 0);
        cycle();
        chk("a_tag_grant", grant, 4'b0010);
        chk("a_tag_data", m_data, 8'hA1);
        chk("a_tag_state", dbg_state, TAG);
        chk("a_tag_sready", s_ready, 0);
        cycle();
        chk("a_d0_grant", grant, 4'b0010);
        chk("a_d0_data", m_data, 8'h11);
        chk("a_d0_sready", s_ready, 4'b0010);
        cycle();
        chk("a_d1_grant", grant, 4'b0010);
        chk("a_d1_data", m_data, 8'h22);
        cycle();
        chk("a_end_grant", grant, 0);
        chk("a_end_valid", m_valid, 0);
        chk("a_end_state", dbg_state, IDLE);

        // Ports 0 and 2 request together after reset: no interleaving
        do_reset();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
        push(2, 8'h03, 1'b0); push(2, 8'h04, 1'b1);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        exp_q.push_back(8'hA2); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
        drain(40);

        // All four ports, two one-byte packets each: 0,1,2,3,0,1,2,3
        do_reset();
        for (int p = 0; p < NP; p++) begin
            push(p, 8'(p * 16 + 1), 1'b1);
            push(p, 8'(p * 16 + 2), 1'b1);
        end
        for (int r = 1; r <= 2; r++) begin
            for (int p = 0; p < NP; p++) begin
                exp_q.push_back(8'hA0 | 8'(p));
                exp_q.push_back(8'(p * 16 + r));
            end
        end
        drain(80);

        // Back-pressure from the uart side: bytes must hold until taken
        rnd_ready = 1'b1;
        push(2, 8'h2A, 1'b0); push(2, 8'h2B, 1'b0); push(2, 8'h2C, 1'b1);
        exp_q.push_back(8'hA2); exp_q.push_back(8'h2A);
        exp_q.push_back(8'h2B); exp_q.push_back(8'h2C);
        drain(200);
        rnd_ready = 1'b0;
        m_ready   = 1'b1;
        cycle();

        // Watchdog: port 3 stalls after one byte, port 0 waits
        push(3, 8'h33, 1'b0);
        push(0, 8'h44, 1'b1);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h33);
        cycle();
        cycle();
        chk("e_tag_grant", grant, 4'b1000);
        cycle();
        chk("e_d_data", m_data, 8'h33);
        cycle();
        edges = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            edges++;
            if (abort) break;
        end
        chk("e_abort_delay", edges, 100);
        chk("e_abort_pulse", abort, 1);
        chk("e_abort_grant", grant, 0);
        chk("e_abort_state", dbg_state, IDLE);
        chk("e_abort_valid", m_valid, 0);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h44);
        cycle();
        chk("e_next_grant", grant, 4'b0001);
        chk("e_next_abort", abort, 0);
        chk("e_next_data", m_data, 8'hA0);
        drain(40);

        // Asynchronous reset in the middle of a packet
        push(1, 8'h55, 1'b0); push(1, 8'h66, 1'b0); push(1, 8'h77, 1'b1);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h55);
        cycle();
        cycle();
        cycle();
        chk("f_pre_state", dbg_state, DATA);
        chk("f_pre_sready", s_ready, 4'b0010);
        #2;
        reset = 1'b0;
        #1;
        chk("f_rst_valid", m_valid, 0);
        chk("f_rst_sready", s_ready, 0);
        chk("f_rst_grant", grant, 0);
        chk("f_rst_data", m_data, 0);
        chk("f_rst_state", dbg_state, IDLE);
        clear_bench();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        push(1, 8'h88, 1'b1);
        push(0, 8'h99, 1'b1);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h99);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h88);
        cycle();
        cycle();
        chk("f_first_grant", grant, 4'b0001);
        chk("f_first_tag", m_data, 8'hA0);
        drain(40);

        chk("exp_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
